// File: rtl/smart_pkg.sv
// smart_pkg: shared FSM state type and key-region defaults for smart_mac and its violation controller
package smart_pkg;
  typedef enum logic [1:0] {IDLE, WIPE, HOLD} smart_state_e;
  localparam int SMART_SIZE_MEM_ADDR = 4;
  localparam int SMART_LOW_SAFE = 8;
  localparam int SMART_HIGH_SAFE = 16;
  localparam int SMART_HOLD_CYCLES = 16;
endpackage

// File: rtl/smart_hold_timer.sv
// smart_hold_timer: loadable down-counter that parks at zero and flags it
module smart_hold_timer #(
  parameter int W = 4
) (
  input  logic         mclk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= load ? load_val : (cnt == '0 ? cnt : cnt - 1'b1);
  assign zero = cnt == '0;
endmodule

// File: rtl/smart_violation_ctrl.sv
// smart_violation_ctrl: scrubs the key region and holds the core in reset after a smart_mac violation,
// keeping a forensic record that only reset_n clears
module smart_violation_ctrl
  import smart_pkg::*;
#(
  parameter int SIZE_MEM_ADDR = SMART_SIZE_MEM_ADDR,
  parameter int LOW_SAFE      = SMART_LOW_SAFE,
  parameter int HIGH_SAFE     = SMART_HIGH_SAFE,
  parameter int HOLD_CYCLES   = SMART_HOLD_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic                     mclk,
  input  logic                     reset_n,
  input  logic                     viol_req,
  input  logic [15:0]              ins_addr,
  input  logic [SIZE_MEM_ADDR:0]   mem_addr,
  output logic [SIZE_MEM_ADDR:0]   wipe_addr,
  output logic [15:0]              wipe_data,
  output logic                     wipe_we,
  input  logic                     wipe_ack,
  output logic                     core_rst,
  output logic                     busy,
  output logic [15:0]              viol_pc,
  output logic [SIZE_MEM_ADDR:0]   viol_addr,
  output logic [CNT_W-1:0]         viol_cnt
);
  localparam int AW = SIZE_MEM_ADDR + 1;
  localparam int TW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [AW-1:0] FIRST = AW'(LOW_SAFE);
  localparam logic [AW-1:0] LAST = AW'(HIGH_SAFE - 1);
  smart_state_e state, state_d;
  logic accept, step, last_ack, hold_done;
  assign accept = state == IDLE && viol_req;
  assign step = state == WIPE && wipe_ack;
  assign last_ack = step && wipe_addr == LAST;
  assign wipe_data = '0;
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (viol_req ? WIPE : IDLE)
            : state == WIPE ? (last_ack ? HOLD : WIPE)
            : (hold_done && !viol_req) ? IDLE : HOLD;
  end
  // control outputs are registered from the next state so they change cleanly with it
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      core_rst <= 1'b0;
      busy     <= 1'b0;
      wipe_we  <= 1'b0;
    end else begin
      state    <= state_d;
      core_rst <= state_d != IDLE;
      busy     <= state_d != IDLE;
      wipe_we  <= state_d == WIPE;
    end
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) begin
      wipe_addr <= '0;
      viol_pc   <= '0;
      viol_addr <= '0;
      viol_cnt  <= '0;
    end else if (accept) begin
      wipe_addr <= FIRST;
      viol_pc   <= ins_addr;
      viol_addr <= mem_addr;
      viol_cnt  <= &viol_cnt ? viol_cnt : viol_cnt + 1'b1;
    end else if (step && !last_ack) begin
      wipe_addr <= wipe_addr + 1'b1;
    end
  smart_hold_timer #(.W(TW)) u_hold (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .load     (last_ack),
    .load_val (TW'(HOLD_CYCLES - 1)),
    .zero     (hold_done)
  );
endmodule

// File: tb/tb_smart_violation_ctrl.sv
// tb_smart_violation_ctrl: randomized episodes checked cycle by cycle against a behavioural model
module tb_smart_violation_ctrl;
  localparam int AW = 5, LOW = 8, HIGH = 16, HOLD = 16;
  logic mclk = 1'b0, reset_n = 1'b0, viol_req = 1'b0, wipe_ack = 1'b0;
  logic [15:0] ins_addr = '0;
  logic [AW-1:0] mem_addr = '0;
  logic [AW-1:0] wipe_addr, viol_addr, s_wipe_addr, s_viol_addr;
  logic [15:0] wipe_data, viol_pc, s_wipe_data, s_viol_pc;
  logic wipe_we, core_rst, busy, s_wipe_we, s_core_rst, s_busy;
  logic [7:0] viol_cnt;
  logic [1:0] s_viol_cnt;
  int n_checks = 0, n_fail = 0;
  int m_busy, m_wiping, m_addr, m_hold, m_pc, m_vaddr, m_cnt;
  int rst_len;
  int wr_q[$];
  always #5 mclk = ~mclk;
  smart_violation_ctrl dut (
    .mclk(mclk), .reset_n(reset_n), .viol_req(viol_req), .ins_addr(ins_addr), .mem_addr(mem_addr),
    .wipe_addr(wipe_addr), .wipe_data(wipe_data), .wipe_we(wipe_we), .wipe_ack(wipe_ack),
    .core_rst(core_rst), .busy(busy), .viol_pc(viol_pc), .viol_addr(viol_addr), .viol_cnt(viol_cnt)
  );
  smart_violation_ctrl #(.CNT_W(2)) u_sat (
    .mclk(mclk), .reset_n(reset_n), .viol_req(viol_req), .ins_addr(ins_addr), .mem_addr(mem_addr),
    .wipe_addr(s_wipe_addr), .wipe_data(s_wipe_data), .wipe_we(s_wipe_we), .wipe_ack(wipe_ack),
    .core_rst(s_core_rst), .busy(s_busy), .viol_pc(s_viol_pc), .viol_addr(s_viol_addr), .viol_cnt(s_viol_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_wiping = 0; m_addr = 0; m_hold = 0; m_pc = 0; m_vaddr = 0; m_cnt = 0;
  endtask
  task automatic compare_all();
    check("core_rst", 32'(core_rst), 32'(m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("wipe_we", 32'(wipe_we), 32'(m_busy && m_wiping));
    check("wipe_addr", 32'(wipe_addr), 32'(m_addr));
    check("wipe_data", 32'(wipe_data), 32'(0));
    check("viol_pc", 32'(viol_pc), 32'(m_pc));
    check("viol_addr", 32'(viol_addr), 32'(m_vaddr));
    check("viol_cnt", 32'(viol_cnt), 32'(m_cnt > 255 ? 255 : m_cnt));
    check("sat_cnt", 32'(s_viol_cnt), 32'(m_cnt > 3 ? 3 : m_cnt));
    check("sat_core_rst", 32'(s_core_rst), 32'(m_busy));
  endtask
  // one clock: drive at the falling edge, advance the model at the rising edge, compare at the next falling edge
  task automatic tick(input logic req, input logic ack);
    viol_req = req;
    wipe_ack = ack;
    if (wipe_we && wipe_ack) wr_q.push_back(int'(wipe_addr));
    @(posedge mclk);
    if (!reset_n) model_reset();
    else if (!m_busy) begin
      if (req) begin
        m_busy = 1; m_wiping = 1; m_addr = LOW;
        m_pc = int'(ins_addr); m_vaddr = int'(mem_addr); m_cnt++;
      end
    end else if (m_wiping) begin
      if (ack) begin
        if (m_addr == HIGH - 1) begin m_wiping = 0; m_hold = HOLD; end
        else m_addr++;
      end
    end else if (m_hold > 1) m_hold--;
    else if (!req) m_busy = 0;
    @(negedge mclk);
    if (core_rst) rst_len++;
    compare_all();
  endtask
  task automatic violation(input logic [15:0] ins, input logic [AW-1:0] mem, input int req_len,
                           input int stall_addr, input int stall_n, input int exp_len, input bit rand_ack);
    int cyc = 0, stalls = stall_n;
    logic ack;
    wr_q.delete();
    rst_len = 0;
    ins_addr = ins;
    mem_addr = mem;
    do begin
      if (m_busy && m_wiping && m_addr == stall_addr && stalls > 0) begin ack = 1'b0; stalls--; end
      else ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(cyc < req_len, ack);
      ins_addr = 16'($urandom);
      mem_addr = AW'($urandom);
      cyc++;
    end while (m_busy && cyc < 400);
    check("write_count", 32'(wr_q.size()), 32'(HIGH - LOW));
    foreach (wr_q[i]) check("write_order", 32'(wr_q[i]), 32'(LOW + i));
    if (exp_len > 0) check("rst_len", 32'(rst_len), 32'(exp_len));
  endtask
  initial begin
    int guard;
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    model_reset();
    #12;
    compare_all();
    @(negedge mclk);
    reset_n = 1'b1;
    tick(1'b0, 1'b1);
    violation(16'h0032, 5'd8, 1, -1, 0, 24, 1'b0);
    check("basic_pc", 32'(viol_pc), 32'h0032);
    check("basic_addr", 32'(viol_addr), 32'd8);
    check("basic_cnt", 32'(viol_cnt), 32'd1);
    tick(1'b0, 1'b1);
    violation(16'($urandom), AW'($urandom), 1, 10, 3, 27, 1'b0);
    tick(1'b0, 1'b0);
    violation(16'h1234, 5'd3, 40, -1, 0, 40, 1'b0);
    check("persist_cnt", 32'(viol_cnt), 32'd3);
    violation(16'h4321, 5'd9, 1, -1, 0, 24, 1'b0);
    violation(16'hBEEF, 5'd17, 1, -1, 0, 24, 1'b0);
    check("b2b_cnt", 32'(viol_cnt), 32'd5);
    for (int k = 0; k < 10; k++) begin
      violation(16'($urandom), AW'($urandom), $urandom_range(1, 40), $urandom_range(8, 15),
                $urandom_range(0, 4), -1, 1'b1);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick(1'b0, 1'($urandom_range(0, 1)));
    end
    tick(1'b1, 1'b1);
    guard = 0;
    while (m_addr != 12 && guard < 50) begin tick(1'b0, 1'b1); guard++; end
    check("pre_reset_addr", 32'(wipe_addr), 32'd12);
    #2 reset_n = 1'b0;
    #1 model_reset();
    wr_q.delete();
    compare_all();
    tick(1'b0, 1'b1);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1);
    check("no_resume", 32'(wr_q.size()), 32'd0);
    for (int k = 0; k < 5; k++) begin
      violation(16'($urandom), AW'($urandom), 1, -1, 0, -1, 1'b1);
      check("sat_seq", 32'(s_viol_cnt), 32'(sat_exp[k]));
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
